// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_stage_pkg;

  localparam int          XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    IF_ST_BOOT  = 2'd0,
    IF_ST_RUN   = 2'd1,
    IF_ST_DRAIN = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Small synchronous FIFO used both as the fetch buffer and as the in-order PC queue.
// DEPTH must be a power of 2; push while full is accepted only together with a pop.
module if_stage_fetch_fifo #(
  parameter  int DEPTH = 2,
  parameter  int W     = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC owner, credit-limited imem requester, fetch buffer and IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetch_count / perf_bubble_count outputs.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_count,
  output logic [31:0] perf_bubble_count
`endif
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  if_state_e     state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] in_flight_q, in_flight_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          if_id_valid_q, if_id_valid_d;
  logic [31:0]   if_id_pc_q, if_id_pc_d;
  logic [31:0]   if_id_instr_q, if_id_instr_d;

  logic          buf_push, buf_pop, buf_clear;
  fetch_entry_t  buf_push_data, buf_head;
  logic [CW-1:0] buf_count, pcq_count;
  logic [31:0]   pcq_head;
  logic          credit_ok, req_fire, resp_keep;

  if_stage_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W($bits(fetch_entry_t))) u_fetch_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (buf_clear),
    .push      (buf_push),
    .push_data (buf_push_data),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // PC queue is never cleared: dropped responses still pop their PC.
  if_stage_fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(XLEN)) u_pc_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (imem_resp_valid),
    .head      (pcq_head),
    .count     (pcq_count)
  );

  assign credit_ok      = ({1'b0, in_flight_q} + {1'b0, buf_count}) < DEPTH_C;
  assign imem_req_valid = !reset && (state_q == IF_ST_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign buf_push_data  = '{pc: pcq_head, instr: imem_resp_data};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_cnt_d  = drop_cnt_q;
    in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_resp_valid);

    if (redirect_valid)  pc_d = align_pc(redirect_pc);
    else if (req_fire)   pc_d = pc_q + 32'd4;

    case (state_q)
      IF_ST_BOOT: state_d = IF_ST_RUN;
      IF_ST_RUN: begin
        if (redirect_valid) begin
          drop_cnt_d = in_flight_q - CW'(imem_resp_valid);
          if (drop_cnt_d != '0) state_d = IF_ST_DRAIN;
        end
      end
      IF_ST_DRAIN: begin
        if (imem_resp_valid) drop_cnt_d = drop_cnt_q - CW'(1);
        if (drop_cnt_d == '0) state_d = IF_ST_RUN;
      end
      default: state_d = IF_ST_BOOT;
    endcase
  end

  always_comb begin
    if_id_valid_d = if_id_valid_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    buf_clear     = 1'b0;

    if (flush || redirect_valid) begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
      buf_clear     = redirect_valid;
      buf_push      = resp_keep;
    end else if (stall) begin
      buf_push = resp_keep;
    end else if (buf_count != '0) begin
      buf_pop       = 1'b1;
      buf_push      = resp_keep;
      if_id_valid_d = 1'b1;
      if_id_pc_d    = buf_head.pc;
      if_id_instr_d = buf_head.instr;
    end else if (resp_keep) begin
      // Empty buffer: the arriving response goes straight to ID.
      if_id_valid_d = 1'b1;
      if_id_pc_d    = pcq_head;
      if_id_instr_d = imem_resp_data;
    end else begin
      if_id_valid_d = 1'b0;
      if_id_pc_d    = '0;
      if_id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IF_ST_BOOT;
      pc_q          <= RESET_PC;
      in_flight_q   <= '0;
      drop_cnt_q    <= '0;
      if_id_valid_q <= 1'b0;
      if_id_pc_q    <= '0;
      if_id_instr_q <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      in_flight_q   <= in_flight_d;
      drop_cnt_q    <= drop_cnt_d;
      if_id_valid_q <= if_id_valid_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
    end
  end

  assign if_id_valid       = if_id_valid_q;
  assign if_id_pc          = if_id_pc_q;
  assign if_id_instruction = if_id_instr_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  // IF/ID reloads every unstalled cycle, so each such cycle is either a fetch or a bubble.
  always_comb begin
    perf_fetch_d  = perf_fetch_q;
    perf_bubble_d = perf_bubble_q;
    if (!stall) begin
      if (if_id_valid_d) perf_fetch_d  = perf_fetch_q + 32'd1;
      else               perf_bubble_d = perf_bubble_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q  <= '0;
      perf_bubble_q <= '0;
    end else begin
      perf_fetch_q  <= perf_fetch_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign perf_fetch_count  = perf_fetch_q;
  assign perf_bubble_count = perf_bubble_q;
`endif

  a_credit: assert property (@(posedge clk) disable iff (reset)
    ({1'b0, in_flight_q} + {1'b0, buf_count}) <= DEPTH_C);
  a_resp_orphan: assert property (@(posedge clk) disable iff (reset)
    !(imem_resp_valid && (in_flight_q == '0)));
  a_pcq_track: assert property (@(posedge clk) disable iff (reset)
    pcq_count == in_flight_q);

endmodule
